// File: rtl/dac_playback_if.sv
// Byte-wide AXI4-Stream link from the DMA MM2S channel into the DAC playback block.
interface dac_playback_if;
    logic [7:0] tdata;
    logic       tkeep;
    logic       tlast;
    logic       tvalid;
    logic       tready;

    // A byte transfers on every rising clock edge where tvalid && tready are both high.
    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/dac_playback.sv
// Reassembles 8-byte frames from the DMA stream into a 2-frame FIFO and releases
// one frame per programmable period to the DAC, with start/abort/done control.
module dac_playback #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 dac_clk,
    input  logic                 dac_rst,
    input  logic [31:0]          play_len,
    input  logic [15:0]          rate_div,
    input  logic                 play_start,
    input  logic                 play_abort,
    output logic                 play_busy,
    output logic                 play_done,
    output logic                 tlast_err,
    output logic [15:0]          underrun_cnt,
    dac_playback_if.slave        dma_axis,
    output logic [63:0]          dac_data,
    output logic                 dac_valid,
    output logic                 play_state
);
    localparam logic [1:0] FIFO_FULL = 2'(FIFO_DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;
    state_t state, state_nxt;

    logic [31:0] len_q, rx_frames, tx_frames;
    logic [15:0] div_q, rate_cnt;
    logic [2:0]  byte_idx;
    logic [63:0] frame_buf;
    logic [63:0] fifo_mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  fifo_cnt;
    logic        primed, tready_q;

    logic        in_play, start_acc, abort_acc, hs, push, final_byte;
    logic        tick, pop, underrun, last_pop, tready_nxt;
    logic [1:0]  cnt_nxt;
    logic [31:0] rx_nxt, len_nxt;
    logic        unused_tkeep;

    assign unused_tkeep = dma_axis.tkeep;

    always_comb begin
        in_play    = (state == S_PLAY) && !play_abort;
        start_acc  = (state == S_IDLE) && play_start;
        abort_acc  = (state == S_PLAY) && play_abort;
        hs         = in_play && dma_axis.tvalid && tready_q;
        push       = hs && (byte_idx == 3'd7);
        final_byte = (rx_frames == len_q - 32'd1) && (byte_idx == 3'd7);
        // The very first buffered frame ticks the pacer before primed is registered.
        tick       = (primed || (fifo_cnt != 2'd0)) && (rate_cnt == 16'd0);
        pop        = in_play && tick && (fifo_cnt != 2'd0);
        underrun   = in_play && tick && (fifo_cnt == 2'd0);
        last_pop   = pop && (tx_frames == len_q - 32'd1);
    end

    // State register
    always_ff @(posedge dac_clk) begin
        if (dac_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (play_start && (play_len != 32'd0)) state_nxt = S_PLAY;
            S_PLAY: if (play_abort || last_pop)            state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        play_busy       = (state == S_PLAY);
        play_state      = state;
        dma_axis.tready = tready_q;
    end

    // tready is registered from the values count/rx/len will hold next cycle.
    always_comb begin
        cnt_nxt = fifo_cnt + 2'(push) - 2'(pop);
        if (start_acc || abort_acc) cnt_nxt = 2'd0;
        rx_nxt  = start_acc ? 32'd0 : rx_frames + 32'(push);
        len_nxt = start_acc ? play_len : len_q;
        tready_nxt = (state_nxt == S_PLAY) && (cnt_nxt < FIFO_FULL) && (rx_nxt < len_nxt);
    end

    always_ff @(posedge dac_clk) begin
        if (push) fifo_mem[wr_ptr] <= {dma_axis.tdata, frame_buf[55:0]};
    end

    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            len_q        <= 32'd0;
            div_q        <= 16'd0;
            rx_frames    <= 32'd0;
            tx_frames    <= 32'd0;
            rate_cnt     <= 16'd0;
            byte_idx     <= 3'd0;
            frame_buf    <= 64'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_cnt     <= 2'd0;
            primed       <= 1'b0;
            tready_q     <= 1'b0;
            play_done    <= 1'b0;
            tlast_err    <= 1'b0;
            underrun_cnt <= 16'd0;
            dac_data     <= 64'd0;
            dac_valid    <= 1'b0;
        end else begin
            play_done <= 1'b0;
            dac_valid <= 1'b0;
            tready_q  <= tready_nxt;
            fifo_cnt  <= cnt_nxt;
            if (start_acc) begin
                len_q        <= play_len;
                div_q        <= rate_div;
                tlast_err    <= 1'b0;
                underrun_cnt <= 16'd0;
                rx_frames    <= 32'd0;
                tx_frames    <= 32'd0;
                primed       <= 1'b0;
                byte_idx     <= 3'd0;
                rate_cnt     <= 16'd0;
                wr_ptr       <= 1'b0;
                rd_ptr       <= 1'b0;
                if (play_len == 32'd0) play_done <= 1'b1;
            end else if (abort_acc) begin
                byte_idx <= 3'd0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
            end else if (in_play) begin
                if (hs) begin
                    frame_buf[{byte_idx, 3'b000} +: 8] <= dma_axis.tdata;
                    byte_idx <= byte_idx + 3'd1;
                    // A misplaced or missing tlast is flagged, but the byte is still used.
                    if (dma_axis.tlast != final_byte) tlast_err <= 1'b1;
                end
                if (push) begin
                    wr_ptr    <= ~wr_ptr;
                    rx_frames <= rx_frames + 32'd1;
                end
                if (fifo_cnt != 2'd0) primed <= 1'b1;
                if (tick)                                 rate_cnt <= div_q;
                else if (primed && (rate_cnt != 16'd0))   rate_cnt <= rate_cnt - 16'd1;
                if (pop) begin
                    dac_data  <= fifo_mem[rd_ptr];
                    dac_valid <= 1'b1;
                    rd_ptr    <= ~rd_ptr;
                    tx_frames <= tx_frames + 32'd1;
                    if (last_pop) play_done <= 1'b1;
                end
                if (underrun && (underrun_cnt != 16'hFFFF))
                    underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_dac_playback.sv
// Directed bench for dac_playback: byte stream driver, dac_valid/play_done log,
// per-scenario tasks with inline expected values.
module tb_dac_playback;
  logic        dac_clk = 1'b0;
  logic        dac_rst;
  logic [31:0] play_len;
  logic [15:0] rate_div;
  logic        play_start, play_abort;
  logic        play_busy, play_done, tlast_err;
  logic [15:0] underrun_cnt;
  logic [63:0] dac_data;
  logic        dac_valid;
  logic        play_state;

  dac_playback_if bus ();

  dac_playback #(.FIFO_DEPTH(2)) dut (
    .dac_clk      (dac_clk),
    .dac_rst      (dac_rst),
    .play_len     (play_len),
    .rate_div     (rate_div),
    .play_start   (play_start),
    .play_abort   (play_abort),
    .play_busy    (play_busy),
    .play_done    (play_done),
    .tlast_err    (tlast_err),
    .underrun_cnt (underrun_cnt),
    .dma_axis     (bus),
    .dac_data     (dac_data),
    .dac_valid    (dac_valid),
    .play_state   (play_state)
  );

  // clock / cycle counter
  always #5 dac_clk = ~dac_clk;
  int cyc = 0;
  always @(posedge dac_clk) cyc <= cyc + 1;

  // output log, sampled mid-cycle
  logic [63:0] val_q[$];
  int          vcyc_q[$];
  int          done_q[$];
  int          tready_hi = 0;
  always @(negedge dac_clk) begin
    if (dac_valid) begin
      val_q.push_back(dac_data);
      vcyc_q.push_back(cyc);
    end
    if (play_done) done_q.push_back(cyc);
    if (bus.tready) tready_hi++;
  end

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          drop_at;
  int          hs7_cyc;

  // driver tasks
  task automatic do_reset();
    dac_rst = 1'b1; play_start = 1'b0; play_abort = 1'b0;
    play_len = 32'd0; rate_div = 16'd0;
    bus.tdata = 8'd0; bus.tkeep = 1'b1; bus.tlast = 1'b0; bus.tvalid = 1'b0;
    repeat (3) @(negedge dac_clk);
    dac_rst = 1'b0;
    @(negedge dac_clk);
  endtask

  task automatic do_start(input logic [31:0] len, input logic [15:0] div, output int c);
    play_len = len; rate_div = div; play_start = 1'b1;
    c = cyc;
    @(negedge dac_clk);
    play_start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] base, input int last_at, output bit ok);
    int i = 0;
    int guard = 0;
    logic rdy;
    ok = 1'b1; drop_at = -1;
    while (i < n) begin
      bus.tdata = base + 8'(i); bus.tlast = (i == last_at); bus.tvalid = 1'b1;
      rdy = bus.tready;
      if (play_busy && !rdy && drop_at < 0) drop_at = i;
      if (rdy && i == 7) hs7_cyc = cyc;
      @(negedge dac_clk);
      if (rdy) i++;
      guard++;
      if (guard > 2000) begin ok = 1'b0; break; end
    end
    bus.tvalid = 1'b0; bus.tlast = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    int guard = 0;
    ok = 1'b1;
    while (done_q.size() < target) begin
      @(negedge dac_clk);
      guard++;
      if (guard > 600) begin ok = 1'b0; break; end
    end
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    checks++;
    if ({play_busy, play_done, dac_valid, tlast_err, bus.tready, play_state} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b exp 000000",
        {play_busy, play_done, dac_valid, tlast_err, bus.tready, play_state});
    end
    checks++;
    if (dac_data !== 64'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", dac_data); end
    checks++;
    if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_underrun: got %0d exp 0", underrun_cnt); end
  endtask

  task automatic test_basic();
    int c, nv, nd; bit ok1, ok2;
    nv = val_q.size(); nd = done_q.size();
    do_start(32'd2, 16'd15, c);
    feed(16, 8'h00, 15, ok1);
    wait_done(nd + 1, ok2);
    @(negedge dac_clk);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL basic_timeout: got feed=%0d done=%0d exp 1 1", ok1, ok2); end
    exp_q.push_back(64'h0706050403020100);
    exp_q.push_back(64'h0F0E0D0C0B0A0908);
    checks++;
    if (val_q.size() != nv + 2) begin
      errors++; $display("FAIL basic_count: got %0d exp 2", val_q.size() - nv);
      exp_q.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        checks++;
        if (val_q[nv + k] !== e) begin errors++; $display("FAIL basic_data%0d: got %h exp %h", k, val_q[nv + k], e); end
      end
      checks++;
      if (vcyc_q[nv + 1] - vcyc_q[nv] != 16) begin
        errors++; $display("FAIL basic_period: got %0d exp 16", vcyc_q[nv + 1] - vcyc_q[nv]);
      end
      checks++;
      if (done_q.size() > nd && done_q[nd] != vcyc_q[nv + 1]) begin
        errors++; $display("FAIL basic_done_align: got %0d exp %0d", done_q[nd], vcyc_q[nv + 1]);
      end
    end
    checks++;
    if ({tlast_err, underrun_cnt, play_busy} !== 18'd0) begin
      errors++; $display("FAIL basic_status: got err=%b und=%0d busy=%b exp 0 0 0", tlast_err, underrun_cnt, play_busy);
    end
  endtask

  task automatic test_backpressure();
    int c, nv, nd, th; bit ok1, ok2;
    nv = val_q.size(); nd = done_q.size(); th = tready_hi;
    do_start(32'd4, 16'd15, c);
    feed(32, 8'h00, 31, ok1);
    checks++;
    if (drop_at != 24) begin errors++; $display("FAIL bp_drop: got %0d exp 24", drop_at); end
    wait_done(nd + 1, ok2);
    @(negedge dac_clk);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL bp_timeout: got feed=%0d done=%0d exp 1 1", ok1, ok2); end
    checks++;
    if (tready_hi - th != 32) begin errors++; $display("FAIL bp_handshakes: got %0d exp 32", tready_hi - th); end
    checks++;
    if (val_q.size() != nv + 4) begin
      errors++; $display("FAIL bp_count: got %0d exp 4", val_q.size() - nv);
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (vcyc_q[nv + k] - vcyc_q[nv + k - 1] != 16) begin
          errors++; $display("FAIL bp_period%0d: got %0d exp 16", k, vcyc_q[nv + k] - vcyc_q[nv + k - 1]);
        end
      end
      checks++;
      if (val_q[nv + 3] !== 64'h1F1E1D1C1B1A1918) begin
        errors++; $display("FAIL bp_data3: got %h exp 1f1e1d1c1b1a1918", val_q[nv + 3]);
      end
      checks++;
      if (done_q.size() > nd && done_q[nd] != vcyc_q[nv + 3]) begin
        errors++; $display("FAIL bp_done_align: got %0d exp %0d", done_q[nd], vcyc_q[nv + 3]);
      end
    end
  endtask

  task automatic test_underrun();
    int c, nv, nd; bit ok1, ok2;
    nv = val_q.size(); nd = done_q.size();
    do_start(32'd2, 16'd0, c);
    feed(16, 8'h40, 15, ok1);
    wait_done(nd + 1, ok2);
    @(negedge dac_clk);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL und_timeout: got feed=%0d done=%0d exp 1 1", ok1, ok2); end
    checks++;
    if (val_q.size() != nv + 2) begin
      errors++; $display("FAIL und_count: got %0d exp 2", val_q.size() - nv);
    end else begin
      checks++;
      if (vcyc_q[nv] - hs7_cyc != 2) begin errors++; $display("FAIL und_latency: got %0d exp 2", vcyc_q[nv] - hs7_cyc); end
    end
    checks++;
    if (underrun_cnt !== 16'd7) begin errors++; $display("FAIL und_count_val: got %0d exp 7", underrun_cnt); end
  endtask

  task automatic test_tlast_err();
    int c, nv, nd, th; bit ok1, ok2;
    nv = val_q.size(); nd = done_q.size(); th = tready_hi;
    do_start(32'd1, 16'd3, c);
    feed(8, 8'h50, 5, ok1);
    wait_done(nd + 1, ok2);
    @(negedge dac_clk);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL tl_timeout: got feed=%0d done=%0d exp 1 1", ok1, ok2); end
    checks++;
    if (tlast_err !== 1'b1) begin errors++; $display("FAIL tl_early: got %b exp 1", tlast_err); end
    checks++;
    if (tready_hi - th != 8) begin errors++; $display("FAIL tl_consumed: got %0d exp 8", tready_hi - th); end
    checks++;
    if (val_q.size() != nv + 1 || val_q[val_q.size() - 1] !== 64'h5756555453525150) begin
      errors++; $display("FAIL tl_frame: got n=%0d exp n=1 data 5756555453525150", val_q.size() - nv);
    end
    nd = done_q.size();
    do_start(32'd1, 16'd3, c);
    checks++;
    if (tlast_err !== 1'b0) begin errors++; $display("FAIL tl_cleared: got %b exp 0", tlast_err); end
    feed(8, 8'h60, -1, ok1);
    wait_done(nd + 1, ok2);
    @(negedge dac_clk);
    checks++;
    if (!(ok1 && ok2) || tlast_err !== 1'b1) begin
      errors++; $display("FAIL tl_missing: got err=%b ok=%0d%0d exp err=1", tlast_err, ok1, ok2);
    end
  endtask

  task automatic test_zero_and_busy_start();
    int c, c2, nv, nd, th; bit ok1, ok2;
    nd = done_q.size(); th = tready_hi;
    do_start(32'd0, 16'd5, c);
    repeat (4) @(negedge dac_clk);
    checks++;
    if (done_q.size() != nd + 1 || done_q[done_q.size() - 1] != c + 1) begin
      errors++; $display("FAIL zero_done: got n=%0d exp n=1 at cycle %0d", done_q.size() - nd, c + 1);
    end
    checks++;
    if (tready_hi != th || play_busy !== 1'b0) begin
      errors++; $display("FAIL zero_idle: got tready_cycles=%0d busy=%b exp 0 0", tready_hi - th, play_busy);
    end
    nv = val_q.size(); nd = done_q.size();
    do_start(32'd2, 16'd3, c);
    feed(4, 8'h10, -1, ok1);
    do_start(32'd5, 16'd3, c2);
    feed(12, 8'h14, 11, ok2);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL busy_feed: got %0d%0d exp 11", ok1, ok2); end
    wait_done(nd + 1, ok1);
    @(negedge dac_clk);
    checks++;
    if (!ok1 || val_q.size() != nv + 2) begin
      errors++; $display("FAIL busy_len: got done=%0d frames=%0d exp 1 2", ok1, val_q.size() - nv);
    end else begin
      checks++;
      if (val_q[nv + 1] !== 64'h1F1E1D1C1B1A1918 || tlast_err !== 1'b0) begin
        errors++; $display("FAIL busy_data: got %h err=%b exp 1f1e1d1c1b1a1918 err=0", val_q[nv + 1], tlast_err);
      end
    end
  endtask

  task automatic test_abort_reset();
    int c, nv, nd; bit ok1, ok2;
    nv = val_q.size(); nd = done_q.size();
    do_start(32'd4, 16'd15, c);
    feed(11, 8'h20, -1, ok1);
    play_abort = 1'b1;
    @(negedge dac_clk);
    play_abort = 1'b0;
    checks++;
    if ({play_busy, bus.tready, play_state} !== 3'b000) begin
      errors++; $display("FAIL abort_idle: got %b exp 000", {play_busy, bus.tready, play_state});
    end
    repeat (20) @(negedge dac_clk);
    checks++;
    if (done_q.size() != nd || val_q.size() != nv + 1) begin
      errors++; $display("FAIL abort_quiet: got done=%0d frames=%0d exp 0 1", done_q.size() - nd, val_q.size() - nv);
    end
    nd = done_q.size();
    do_start(32'd1, 16'd0, c);
    feed(8, 8'hA0, 7, ok1);
    wait_done(nd + 1, ok2);
    @(negedge dac_clk);
    checks++;
    if (!(ok1 && ok2) || dac_data !== 64'hA7A6A5A4A3A2A1A0 || tlast_err !== 1'b0) begin
      errors++; $display("FAIL abort_restart: got %h err=%b exp a7a6a5a4a3a2a1a0 err=0", dac_data, tlast_err);
    end
    do_start(32'd4, 16'd0, c);
    feed(11, 8'h30, 2, ok1);
    checks++;
    if (dac_data !== 64'h3736353433323130 || tlast_err !== 1'b1 || underrun_cnt !== 16'd2) begin
      errors++; $display("FAIL prerst_state: got %h err=%b und=%0d exp 3736353433323130 1 2", dac_data, tlast_err, underrun_cnt);
    end
    dac_rst = 1'b1;
    @(negedge dac_clk);
    checks++;
    if ({play_busy, play_done, dac_valid, tlast_err, bus.tready, play_state} !== 6'b0
        || dac_data !== 64'd0 || underrun_cnt !== 16'd0) begin
      errors++; $display("FAIL midrst_outputs: got flags=%b data=%h und=%0d exp all 0",
        {play_busy, play_done, dac_valid, tlast_err, bus.tready, play_state}, dac_data, underrun_cnt);
    end
    dac_rst = 1'b0;
    repeat (3) @(negedge dac_clk);
    checks++;
    if ({play_busy, bus.tready, dac_valid} !== 3'b000) begin
      errors++; $display("FAIL postrst_idle: got %b exp 000", {play_busy, bus.tready, dac_valid});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_underrun();
    test_tlast_err();
    test_zero_and_busy_start();
    test_abort_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac_playback.md
# dac_playback

AXI4-Stream slave fed by the DMA MM2S channel, the transmit-side counterpart of the ADC sample path. It accepts the same 8-bit byte stream format the sampler produces: 8 bytes per frame, 4 channels × 16 bit. It reassembles the bytes into 64-bit frames and buffers them in a 2-frame FIFO. A programmable pacer then releases one frame per output period to the DAC interface. Control mirrors the sampler: frame count, start, busy and done, plus error and underrun status for software.

## Interface
- `FIFO_DEPTH`, 2 — frame buffer depth in frames; fixed at 2.
- `dac_clk`  in  1  — single clock; DMA side and DAC side both run on it.
- `dac_rst`  in  1  — reset, synchronous, active-high.
- `play_len`  in  32  — frames to play; captured on start.
- `rate_div`  in  16  — output period minus 1, in `dac_clk` cycles; captured on start.
- `play_start`  in  1  — start request; ignored while busy.
- `play_abort`  in  1  — abort; returns to IDLE.
- `play_busy`  out  1  — high in PLAY.
- `play_done`  out  1  — one-cycle pulse on completion.
- `tlast_err`  out  1  — sticky tlast framing error.
- `underrun_cnt`  out  16  — saturating count of empty ticks.
- `DMA_AXIS_tdata`  in  8  — stream byte.
- `DMA_AXIS_tkeep`  in  1  — ignored; all bytes are treated as valid.
- `DMA_AXIS_tlast`  in  1  — end of packet.
- `DMA_AXIS_tvalid`  in  1  — byte valid.
- `DMA_AXIS_tready`  out  1  — byte accept.
- `dac_data`  out  64  — frame; ch n = `[16n+15:16n]`.
- `dac_valid`  out  1  — one-cycle strobe per emitted frame.

## Operation
- **Reset values:** all outputs 0; state IDLE; FIFO empty; all counters 0.
- **IDLE**
  - `DMA_AXIS_tready` = 0.
  - On `play_start`:
    - Capture `play_len` and `rate_div`.
    - Clear `tlast_err`, `underrun_cnt`, `rx_frames`, `tx_frames`, `primed`, and the byte index.
    - If `play_len` = 0: pulse `play_done` next cycle and stay in IDLE.
    - Otherwise go to PLAY.
- **PLAY: accept side**
  - `DMA_AXIS_tready` = (FIFO count < 2) && (`rx_frames` < `play_len`).
  - Handshake = `tvalid` && `tready`. The byte at index k (0..7) is written to `frame[8k+7:8k]` (little-endian).
  - On the byte at index 7: push the frame, `rx_frames`+1, index wraps to 0.
  - A push and a pop in the same cycle are both allowed; count is unchanged.
- **tlast check**
  - `tlast_err` is set if `tlast`=1 on any byte other than index 7 of frame `play_len`-1.
  - `tlast_err` is also set if that final byte has `tlast`=0.
  - The offending byte is still consumed; playback continues.
- **PLAY: pacer**
  - `primed` sets on the first cycle the registered FIFO count is non-zero.
  - `rate_cnt` starts at 0 and decrements only while `primed` and nonzero.
  - tick = `primed` && `rate_cnt` == 0. On a tick, reload `rate_cnt` with `rate_div`.
  - Tick with FIFO non-empty: pop, register `dac_data`, assert `dac_valid` next cycle, `tx_frames`+1.
  - Tick with FIFO empty: `underrun_cnt`+1, saturating at 0xFFFF; `dac_data` holds its value.
- **Completion:** in the cycle `dac_valid` is asserted for frame `play_len`-1:
  - `play_done`=1 and `play_busy`=0 in that same cycle.
  - State returns to IDLE.
- **Abort:** `play_abort` in PLAY causes, next cycle:
  - state IDLE, FIFO flushed, byte index 0, `tready` 0;
  - no `play_done`; status registers hold.
  - `play_abort` has priority over the accept and pacer actions in the same cycle.
- **Priorities:** `dac_rst` > `play_abort` > normal operation.
- **Arithmetic:** frame counters are 32-bit unsigned, compared for equality with the captured `play_len`; no wrap occurs since counting stops at `play_len`.

## Timing
- Byte accepted at cycle t → `frame[8k+7:8k]` written at t+1.
- 8th byte of a frame accepted at t → FIFO count reflects the frame at t+1.
  - If that frame primes the pacer, it is popped at t+1.
  - `dac_valid`/`dac_data` appear at t+2.
- `tready` is registered from FIFO count and state: it falls the cycle after the count reaches 2 and rises the cycle after a pop.
  - No byte is ever lost: the byte at index 7 is accepted only when count < 2.
- Output period once primed: exactly `rate_div`+1 cycles between ticks.
- Reset asserted mid-PLAY: the next cycle equals the reset state; any partial frame is discarded.

## Test plan
1. **Basic playback.** `play_len`=2, `rate_div`=15; bytes 0x00..0x0F with `tlast` on 0x0F, continuous `tvalid`.
   - `dac_data` = 0x0706050403020100, then 0x0F0E0D0C0B0A0908, 16 cycles apart.
   - `play_done` coincides with the 2nd `dac_valid`; `tlast_err`=0; `underrun_cnt`=0.
2. **Backpressure.** `play_len`=4, `rate_div`=15, continuous `tvalid`.
   - `tready` drops after 16 bytes are buffered and re-opens 8 bytes per pop.
   - 4 `dac_valid` strobes, each exactly 16 cycles apart; 32 handshakes total.
3. **Underrun.** `play_len`=2, `rate_div`=0, continuous `tvalid`.
   - Frame 0 emitted 2 cycles after its 8th byte.
   - `underrun_cnt`=7 at done.
4. **tlast error.** `play_len`=1 with `tlast` on byte 5 → `tlast_err`=1; all 8 bytes consumed; frame emitted; `play_done` pulses.
   - Separately, no `tlast` on the final byte → `tlast_err`=1.
5. **Zero length and start while busy.** `play_len`=0 → `play_done` one cycle after start; `tready` never high.
   - `play_start` pulsed during PLAY → ignored; the captured length is unchanged.
6. **Abort and reset mid-stream.** `play_len`=4, abort after 11 bytes → next cycle: IDLE, `tready`=0, no `play_done`.
   - A new start with `play_len`=1 plays correctly from byte index 0.
   - The same sequence with `dac_rst` instead of abort → all outputs 0.
